// File: rtl/ps2_front_pkg.sv
// Shared constants and helpers for the PS/2 receive front end.
// A frame is 11 falling clock edges: start, 8 data bits, parity, stop.
package ps2_front_pkg;

    localparam int   FRAME_EDGES = 11;
    localparam int   LAST_EDGE   = FRAME_EDGES - 1;
    localparam logic PS2_IDLE    = 1'b1;

    localparam int BIT_CNT_W = 4;
    typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

    function automatic logic is_last_edge(input bit_cnt_t cnt);
        return cnt == BIT_CNT_W'(LAST_EDGE);
    endfunction

endpackage

// File: rtl/ps2_front_if.sv
// Raw PS/2 lines in, edge strobe and frame-tracking pulses out.
// The slave modport is the front end; the master modport is its driver/consumer.
interface ps2_front_if;

    logic i_ps2_clk;
    logic i_ps2_dat;
    logic o_en;
    logic o_dat;
    logic o_sclr;
    logic o_done;
    logic o_busy;

    modport master (
        output i_ps2_clk,
        output i_ps2_dat,
        input  o_en,
        input  o_dat,
        input  o_sclr,
        input  o_done,
        input  o_busy
    );

    modport slave (
        input  i_ps2_clk,
        input  i_ps2_dat,
        output o_en,
        output o_dat,
        output o_sclr,
        output o_done,
        output o_busy
    );

endinterface

// File: rtl/ps2_front_sync_filter.sv
// Synchroniser chain plus FILTER_LEN-sample hold filter for one raw line.
// o_fall is high in the cycle whose clock edge takes the filtered line 1->0.
module ps2_sync_filter
    import ps2_front_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FILTER_LEN-1:0]  shift_q, shift_d;
    logic                   filt_q, filt_d;
    logic                   all_low;
    logic                   all_high;

    // The filtered line only moves once the whole window agrees; anything mixed holds.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], i_raw};
        shift_d  = {shift_q[FILTER_LEN-2:0], sync_q[SYNC_STAGES-1]};
        all_low  = (shift_q == '0);
        all_high = (shift_q == '1);
        filt_d   = filt_q;
        if (all_low) begin
            filt_d = 1'b0;
        end else if (all_high) begin
            filt_d = 1'b1;
        end
    end

    assign o_fall = filt_q & all_low;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= {SYNC_STAGES{PS2_IDLE}};
            shift_q <= {FILTER_LEN{PS2_IDLE}};
            filt_q  <= PS2_IDLE;
        end else begin
            sync_q  <= sync_d;
            shift_q <= shift_d;
            filt_q  <= filt_d;
        end
    end

endmodule

// File: rtl/ps2_front.sv
// PS/2 receive front end: clock filtering, per-edge data strobe, frame position
// tracking with mid-frame timeout abort and end-of-frame pulse.
module ps2_front
    import ps2_front_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 5000,
    parameter int CNT_W       = 13
) (
    input  logic        clk,
    input  logic        i_rst,
    ps2_front_if.slave  bus
);

    // Abort fires on the edge that would have loaded TIMEOUT_CYC-1, so o_sclr
    // lands TIMEOUT_CYC-1 cycles after the counter was last cleared.
    localparam logic [CNT_W-1:0] TMO_PRE = CNT_W'(TIMEOUT_CYC - 2);

    logic                   fall;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   en_q, en_d;
    logic                   dat_q, dat_d;
    logic                   sclr_q, sclr_d;
    logic                   wrap_q, wrap_d;
    logic                   done_q, done_d;
    bit_cnt_t               cnt_q, cnt_d;
    logic [CNT_W-1:0]       tmo_q, tmo_d;
    logic                   tmo_hit;

    ps2_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_clk_filt (
        .clk    (clk),
        .rst    (i_rst),
        .i_raw  (bus.i_ps2_clk),
        .o_fall (fall)
    );

    // A falling edge always beats a coincident timeout.
    always_comb begin
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], bus.i_ps2_dat};
        tmo_hit    = (cnt_q != '0) && (tmo_q == TMO_PRE);
        en_d       = fall;
        dat_d      = fall ? dat_sync_q[SYNC_STAGES-1] : dat_q;
        wrap_d     = fall && is_last_edge(cnt_q);
        done_d     = wrap_q;
        sclr_d     = 1'b0;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q + 1'b1;
        if (fall) begin
            cnt_d = is_last_edge(cnt_q) ? '0 : cnt_q + 1'b1;
            tmo_d = '0;
        end else if (cnt_q == '0) begin
            tmo_d = '0;
        end else if (tmo_hit) begin
            sclr_d = 1'b1;
            cnt_d  = '0;
            tmo_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            dat_sync_q <= {SYNC_STAGES{PS2_IDLE}};
            en_q       <= 1'b0;
            dat_q      <= PS2_IDLE;
            sclr_q     <= 1'b0;
            wrap_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            tmo_q      <= '0;
        end else begin
            dat_sync_q <= dat_sync_d;
            en_q       <= en_d;
            dat_q      <= dat_d;
            sclr_q     <= sclr_d;
            wrap_q     <= wrap_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
        end
    end

    assign bus.o_en   = en_q;
    assign bus.o_dat  = dat_q;
    assign bus.o_sclr = sclr_q;
    assign bus.o_done = done_q;
    assign bus.o_busy = (cnt_q != '0);

endmodule

// File: tb/tb_ps2_front.sv
// Directed bench for ps2_front: clean frame, glitches, timeout, edge/timeout
// collision, async reset mid-frame and back-to-back frames.
module tb_ps2_front;

    localparam int T = 5000;
    localparam logic [10:0] EXP_1C = 11'b10000111000;

    logic clk = 1'b0;
    logic rst;

    ps2_front_if bus();

    ps2_front #(
        .SYNC_STAGES (2),
        .FILTER_LEN  (8),
        .TIMEOUT_CYC (T),
        .CNT_W       (13)
    ) dut (
        .clk   (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int fall_cyc = 0;

    int   en_cyc_q[$];
    int   lat_q[$];
    logic dat_q[$];
    int   done_cyc_q[$];
    int   sclr_cyc_q[$];
    logic sclr_busy_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Outputs are logged on the falling clk edge, well away from the active edge.
    always @(negedge clk) begin
        if (bus.o_en === 1'b1) begin
            en_cyc_q.push_back(cyc);
            lat_q.push_back(cyc - fall_cyc);
            dat_q.push_back(bus.o_dat);
        end
        if (bus.o_done === 1'b1) done_cyc_q.push_back(cyc);
        if (bus.o_sclr === 1'b1) begin
            sclr_cyc_q.push_back(cyc);
            sclr_busy_q.push_back(bus.o_busy);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clearLogs();
        en_cyc_q.delete();
        lat_q.delete();
        dat_q.delete();
        done_cyc_q.delete();
        sclr_cyc_q.delete();
        sclr_busy_q.delete();
    endtask

    task automatic ps2Low();
        bus.i_ps2_clk = 1'b0;
        fall_cyc      = cyc;
    endtask

    task automatic waitEn(output int seen, input int bound);
        seen = -1;
        for (int k = 0; k < bound && seen < 0; k++) begin
            @(negedge clk);
            if (bus.o_en === 1'b1) seen = cyc;
        end
    endtask

    task automatic applyStimulus(input logic [10:0] bits, input int n_edges, input int h);
        for (int i = 0; i < n_edges; i++) begin
            bus.i_ps2_dat = bits[i];
            waitCycles(h);
            ps2Low();
            waitCycles(h);
            bus.i_ps2_clk = 1'b1;
        end
    endtask

    task automatic asyncReset();
        @(negedge clk);
        #2 rst = 1'b1;
        bus.i_ps2_clk = 1'b1;
        bus.i_ps2_dat = 1'b1;
        waitCycles(3);
        rst = 1'b0;
        waitCycles(5);
    endtask

    function automatic logic [10:0] frameBits(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    function automatic int qInt(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    initial begin
        logic [10:0] exp_bits;
        logic [21:0] exp_two;
        int          e;
        int          seen;
        int          k;

        rst           = 1'b1;
        bus.i_ps2_clk = 1'b1;
        bus.i_ps2_dat = 1'b1;
        waitCycles(3);
        checkOutput("rst_en",   bus.o_en,   0);
        checkOutput("rst_dat",  bus.o_dat,  1);
        checkOutput("rst_sclr", bus.o_sclr, 0);
        checkOutput("rst_done", bus.o_done, 0);
        checkOutput("rst_busy", bus.o_busy, 0);
        rst = 1'b0;
        waitCycles(5);

        $display("[TB] clean frame 0x1C");
        clearLogs();
        applyStimulus(frameBits(8'h1C), 11, 2000);
        waitCycles(20);
        exp_bits = EXP_1C;
        checkOutput("clean_en_count", en_cyc_q.size(), 11);
        for (int i = 0; i < 11; i++) begin
            checkOutput($sformatf("clean_lat%0d", i), qInt(lat_q, i), 11);
            checkOutput($sformatf("clean_dat%0d", i), (i < dat_q.size()) ? dat_q[i] : 1'bx, exp_bits[i]);
        end
        checkOutput("clean_done_count", done_cyc_q.size(), 1);
        checkOutput("clean_done_cyc", qInt(done_cyc_q, 0), qInt(en_cyc_q, 10) + 1);
        checkOutput("clean_sclr_count", sclr_cyc_q.size(), 0);
        checkOutput("clean_busy_end", bus.o_busy, 0);

        $display("[TB] glitch rejection");
        clearLogs();
        foreach (exp_two[i]) exp_two[i] = 1'b0;
        for (int g = 0; g < 3; g++) begin
            ps2Low();
            waitCycles(g == 0 ? 1 : (g == 1 ? 5 : 7));
            bus.i_ps2_clk = 1'b1;
            waitCycles(30);
            checkOutput($sformatf("glitch_%0d_en", g), en_cyc_q.size(), 0);
        end
        ps2Low();
        waitCycles(8);
        bus.i_ps2_clk = 1'b1;
        waitCycles(30);
        checkOutput("glitch8_en", en_cyc_q.size(), 1);
        checkOutput("glitch8_lat", qInt(lat_q, 0), 11);
        checkOutput("glitch8_busy", bus.o_busy, 1);
        asyncReset();

        $display("[TB] timeout");
        clearLogs();
        applyStimulus(frameBits(8'h00), 4, 40);
        checkOutput("tmo_busy_pre", bus.o_busy, 1);
        k = 0;
        while (k < 6000 && sclr_cyc_q.size() == 0) begin
            waitCycles(1);
            k++;
        end
        waitCycles(5);
        checkOutput("tmo_en_count", en_cyc_q.size(), 4);
        checkOutput("tmo_sclr_count", sclr_cyc_q.size(), 1);
        checkOutput("tmo_sclr_cyc", qInt(sclr_cyc_q, 0) - qInt(en_cyc_q, 3), T - 1);
        checkOutput("tmo_busy_at_sclr", (sclr_busy_q.size() > 0) ? sclr_busy_q[0] : 1'bx, 0);
        checkOutput("tmo_done_count", done_cyc_q.size(), 0);
        checkOutput("tmo_busy_post", bus.o_busy, 0);

        $display("[TB] edge/timeout collision");
        asyncReset();
        clearLogs();
        applyStimulus(frameBits(8'h00), 3, 40);
        waitCycles(40);
        ps2Low();
        waitEn(e, 40);
        checkOutput("col_en4_lat", e - fall_cyc, 11);
        waitCycles(20);
        bus.i_ps2_clk = 1'b1;
        k = 0;
        while (cyc < e + T - 12 && k < T) begin
            waitCycles(1);
            k++;
        end
        ps2Low();
        waitEn(seen, 40);
        checkOutput("col_en5_cyc", seen - e, T - 1);
        waitCycles(5);
        checkOutput("col_sclr_count", sclr_cyc_q.size(), 0);
        checkOutput("col_busy", bus.o_busy, 1);
        checkOutput("col_en_count", en_cyc_q.size(), 5);
        bus.i_ps2_clk = 1'b1;
        asyncReset();

        $display("[TB] async reset mid-frame");
        clearLogs();
        exp_bits = frameBits(8'h1C);
        applyStimulus(exp_bits, 6, 40);
        bus.i_ps2_dat = exp_bits[6];
        waitCycles(40);
        ps2Low();
        waitEn(seen, 40);
        checkOutput("ar_pre_en", bus.o_en, 1);
        checkOutput("ar_pre_dat", bus.o_dat, 0);
        checkOutput("ar_pre_busy", bus.o_busy, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("ar_en",   bus.o_en,   0);
        checkOutput("ar_dat",  bus.o_dat,  1);
        checkOutput("ar_busy", bus.o_busy, 0);
        checkOutput("ar_sclr", bus.o_sclr, 0);
        checkOutput("ar_done", bus.o_done, 0);
        bus.i_ps2_clk = 1'b1;
        bus.i_ps2_dat = 1'b1;
        waitCycles(3);
        rst = 1'b0;
        waitCycles(20);
        clearLogs();
        exp_bits = frameBits(8'h5A);
        applyStimulus(exp_bits, 11, 40);
        waitCycles(20);
        checkOutput("ar_frame_en_count", en_cyc_q.size(), 11);
        checkOutput("ar_frame_done_count", done_cyc_q.size(), 1);
        checkOutput("ar_frame_sclr_count", sclr_cyc_q.size(), 0);
        for (int i = 0; i < 11; i++)
            checkOutput($sformatf("ar_frame_dat%0d", i), (i < dat_q.size()) ? dat_q[i] : 1'bx, exp_bits[i]);

        $display("[TB] back-to-back frames");
        clearLogs();
        exp_two = {frameBits(8'h3C), frameBits(8'hE7)};
        applyStimulus(exp_two[10:0], 11, 40);
        applyStimulus(exp_two[21:11], 11, 40);
        waitCycles(20);
        checkOutput("b2b_en_count", en_cyc_q.size(), 22);
        checkOutput("b2b_done_count", done_cyc_q.size(), 2);
        checkOutput("b2b_done0_cyc", qInt(done_cyc_q, 0), qInt(en_cyc_q, 10) + 1);
        checkOutput("b2b_done1_cyc", qInt(done_cyc_q, 1), qInt(en_cyc_q, 21) + 1);
        checkOutput("b2b_sclr_count", sclr_cyc_q.size(), 0);
        checkOutput("b2b_busy_end", bus.o_busy, 0);
        for (int i = 0; i < 22; i++)
            checkOutput($sformatf("b2b_dat%0d", i), (i < dat_q.size()) ? dat_q[i] : 1'bx, exp_two[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
